vram_wr_sched: RTL and testbench



---
 rtl/vram_wr_sched_if.sv | 28 ++
 rtl/vram_wr_sched.sv | 96 +++++++++
 tb/tb_vram_wr_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vram_wr_sched_if.sv
// vram_wr_sched_if: pen handshake, clear control and frame-buffer write port bundle
interface vram_wr_sched_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              pen_req;
    logic [ADDR_W-1:0] pen_addr;
    logic [DATA_W-1:0] pen_data;
    logic              pen_ack;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              oob_err;

    modport master (
        output pen_req, pen_addr, pen_data, clr_start, clr_color,
        input  pen_ack, clr_busy, clr_done, waddr, wdata, we, oob_err
    );

    modport slave (
        input  pen_req, pen_addr, pen_data, clr_start, clr_color,
        output pen_ack, clr_busy, clr_done, waddr, wdata, we, oob_err
    );
endinterface

// File: rtl/vram_wr_sched.sv
// vram_wr_sched: frame-buffer write-port arbiter between pen writes and a bulk clear sweep (optional VRAM_BOUNDS_CHECK_EN)
module vram_wr_sched #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 30000
) (
    input logic            clk,
    input logic            rstn,
    vram_wr_sched_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] color, color_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              we_n, ack_n, busy_n, done_n, oob_n;
    logic              pen_ok;

`ifdef VRAM_BOUNDS_CHECK_EN
    assign pen_ok = bus.pen_addr < ADDR_W'(DEPTH);
`else
    assign pen_ok = 1'b1;
`endif

    // next state and next registered outputs; clear wins over pen, pen waits out the clr_done cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = color;
        waddr_n = bus.waddr;
        wdata_n = bus.wdata;
        we_n    = 1'b0;
        ack_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
`ifdef VRAM_BOUNDS_CHECK_EN
        oob_n   = bus.oob_err;
`else
        oob_n   = 1'b0;
`endif
        if (state == CLEAR) begin
            we_n    = 1'b1;
            busy_n  = 1'b1;
            waddr_n = cnt;
            wdata_n = color;
            cnt_n   = (cnt == LAST) ? '0 : cnt + 1'b1;
            state_n = (cnt == LAST) ? IDLE : CLEAR;
        end else begin
            done_n = bus.clr_busy;
            if (bus.clr_start) begin
                state_n = CLEAR;
                cnt_n   = '0;
                color_n = bus.clr_color;
            end else if (bus.pen_req && !bus.pen_ack && !bus.clr_busy) begin
                ack_n   = 1'b1;
                we_n    = pen_ok;
                waddr_n = bus.pen_addr;
                wdata_n = bus.pen_data;
`ifdef VRAM_BOUNDS_CHECK_EN
                oob_n   = bus.oob_err | !pen_ok;
`endif
            end
        end
    end

    // state, sweep counter, latched colour and all outputs registered with sync active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            color       <= '0;
            bus.waddr   <= '0;
            bus.wdata   <= '0;
            bus.we      <= 1'b0;
            bus.pen_ack <= 1'b0;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.oob_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            color       <= color_n;
            bus.waddr   <= waddr_n;
            bus.wdata   <= wdata_n;
            bus.we      <= we_n;
            bus.pen_ack <= ack_n;
            bus.clr_busy <= busy_n;
            bus.clr_done <= done_n;
            bus.oob_err <= oob_n;
        end
    end
endmodule

// File: tb/tb_vram_wr_sched.sv
// tb_vram_wr_sched: directed self-checking bench for vram_wr_sched
module tb_vram_wr_sched;
    localparam int DEPTH = 30000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    vram_wr_sched_if #(.ADDR_W(15), .DATA_W(12)) bus ();

    vram_wr_sched #(.ADDR_W(15), .DATA_W(12), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int n_we;
        int done_seen;
        bus.pen_req   = 1'b0;
        bus.pen_addr  = '0;
        bus.pen_data  = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
        tick();
        tick();
        chk("rst_we", bus.we, 0);
        chk("rst_waddr", bus.waddr, 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_we", bus.we, 0);
        chk("idle_ack", bus.pen_ack, 0);
        chk("idle_busy", bus.clr_busy, 0);
        chk("idle_done", bus.clr_done, 0);
        chk("idle_oob", bus.oob_err, 0);

        bus.pen_req  = 1'b1;
        bus.pen_addr = 15'h0064;
        bus.pen_data = 12'hF00;
        tick();
        chk("pen_ack", bus.pen_ack, 1);
        chk("pen_we", bus.we, 1);
        chk("pen_waddr", bus.waddr, 32'h64);
        chk("pen_wdata", bus.wdata, 32'hF00);
        tick();
        chk("pen_gap_ack", bus.pen_ack, 0);
        chk("pen_gap_we", bus.we, 0);
        tick();
        chk("pen_ack2", bus.pen_ack, 1);
        bus.pen_req = 1'b0;
        tick();
        chk("pen_end_ack", bus.pen_ack, 0);
        tick();
        chk("pen_end_we", bus.we, 0);

        bus.clr_start = 1'b1;
        bus.clr_color = 12'h0F0;
        tick();
        bus.clr_start = 1'b0;
        chk("clr_n_we", bus.we, 0);
        chk("clr_n_busy", bus.clr_busy, 0);
        bad = 0;
        n_we = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.clr_start = (i == 500);
            bus.clr_color = (i == 500) ? 12'h00F : 12'h0F0;
            tick();
            n_we += int'(bus.we);
            if (bus.we !== 1'b1 || bus.waddr !== 15'(i) || bus.wdata !== 12'h0F0 ||
                bus.clr_busy !== 1'b1 || bus.clr_done !== 1'b0 || bus.pen_ack !== 1'b0) bad++;
        end
        bus.clr_start = 1'b0;
        chk("clr_we_count", n_we, DEPTH);
        chk("clr_bad_cycles", bad, 0);
        tick();
        chk("clr_done", bus.clr_done, 1);
        chk("clr_done_we", bus.we, 0);
        chk("clr_done_busy", bus.clr_busy, 0);
        tick();
        chk("clr_done_once", bus.clr_done, 0);
        chk("clr_after_we", bus.we, 0);

        bus.clr_start = 1'b1;
        bus.clr_color = 12'h123;
        bus.pen_req   = 1'b1;
        bus.pen_addr  = 15'h0005;
        bus.pen_data  = 12'hABC;
        tick();
        bus.clr_start = 1'b0;
        chk("mix_n_ack", bus.pen_ack, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (bus.we !== 1'b1 || bus.waddr !== 15'(i) || bus.wdata !== 12'h123 ||
                bus.pen_ack !== 1'b0) bad++;
        end
        chk("mix_bad_cycles", bad, 0);
        tick();
        chk("mix_done", bus.clr_done, 1);
        chk("mix_done_we", bus.we, 0);
        chk("mix_done_ack", bus.pen_ack, 0);
        tick();
        chk("mix_pen_ack", bus.pen_ack, 1);
        chk("mix_pen_we", bus.we, 1);
        chk("mix_pen_waddr", bus.waddr, 5);
        chk("mix_pen_wdata", bus.wdata, 32'hABC);
        bus.pen_req = 1'b0;
        tick();
        chk("mix_end_we", bus.we, 0);

        bus.clr_start = 1'b1;
        bus.clr_color = 12'h456;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i <= 1000; i++) tick();
        chk("abort_at_addr", bus.waddr, 1000);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_we", bus.we, 0);
        chk("abort_busy", bus.clr_busy, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_seen += int'(bus.clr_done) + int'(bus.we);
        end
        chk("abort_quiet", done_seen, 0);
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h789;
        tick();
        bus.clr_start = 1'b0;
        tick();
        chk("restart_we", bus.we, 1);
        chk("restart_waddr", bus.waddr, 0);
        chk("restart_wdata", bus.wdata, 32'h789);
        tick();
        chk("restart_waddr1", bus.waddr, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        bus.pen_req  = 1'b1;
        bus.pen_addr = 15'd30000;
        bus.pen_data = 12'h111;
        tick();
        bus.pen_req = 1'b0;
        chk("oob_ack", bus.pen_ack, 1);
`ifdef VRAM_BOUNDS_CHECK_EN
        chk("oob_we", bus.we, 0);
        chk("oob_flag", bus.oob_err, 1);
        tick();
        tick();
        chk("oob_sticky", bus.oob_err, 1);
`else
        chk("oob_we", bus.we, 1);
        chk("oob_waddr", bus.waddr, 30000);
        chk("oob_flag", bus.oob_err, 0);
        tick();
        tick();
        chk("oob_stays0", bus.oob_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
